// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped 16x16-bit data cache between MEM stage and data RAM
// DCACHE_WRITE_BACK_EN selects write-back/write-allocate; default is write-through/no-allocate.
module data_cache (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WB, FILL, WT} state_t;

  state_t      state, next_state;
  logic [15:0] valid;
  logic [3:0]  tag_mem  [16];
  logic [15:0] data_mem [16];
  logic [7:0]  lat_addr;
  logic [3:0]  idx, lat_idx;
  logic        hit, store_upd, fill_done;
`ifdef DCACHE_WRITE_BACK_EN
  logic [15:0] dirty;
  logic        victim_dirty;
`else
  logic        done;
`endif

  assign idx       = cpu_addr[3:0];
  assign lat_idx   = lat_addr[3:0];
  assign hit       = cpu_req & valid[idx] & (tag_mem[idx] == cpu_addr[7:4]);
  assign cpu_rdata = data_mem[idx];
  assign fill_done = (state == FILL) & mem_ack;
`ifdef DCACHE_WRITE_BACK_EN
  assign victim_dirty = valid[idx] & dirty[idx];
`endif

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    store_upd  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
`ifdef DCACHE_WRITE_BACK_EN
          if (hit) begin
            store_upd = cpu_we;
          end else begin
            stall      = 1'b1;
            next_state = victim_dirty ? WB : FILL;
          end
`else
          if (!cpu_we) begin
            if (!hit) begin
              stall      = 1'b1;
              next_state = FILL;
            end
          end else if (done) begin
            // Memory write already acknowledged; update only a resident line.
            store_upd = hit;
          end else begin
            stall      = 1'b1;
            next_state = WT;
          end
`endif
        end
      end
`ifdef DCACHE_WRITE_BACK_EN
      WB: begin
        stall = 1'b1;
        if (mem_ack) next_state = FILL;
      end
`else
      WT: begin
        stall = 1'b1;
        if (mem_ack) next_state = IDLE;
      end
`endif
      FILL: begin
        stall = 1'b1;
        if (mem_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      lat_addr  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DCACHE_WRITE_BACK_EN
      dirty     <= '0;
`else
      done      <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (state == IDLE && next_state != IDLE) lat_addr <= cpu_addr;
      // Memory port is loaded on state entry and held until the state is left.
      if (next_state != state) begin
        case (next_state)
          FILL: begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= (state == IDLE) ? cpu_addr : lat_addr;
          end
          WB: begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_mem[idx], idx};
            mem_wdata <= data_mem[idx];
          end
          WT: begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end
          default: begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        endcase
      end
      if (fill_done) valid[lat_idx] <= 1'b1;
`ifdef DCACHE_WRITE_BACK_EN
      if (fill_done) dirty[lat_idx] <= 1'b0;
      else if (store_upd) dirty[idx] <= 1'b1;
`else
      if (state == WT && mem_ack) done <= 1'b1;
      else if (state == IDLE && cpu_req && cpu_we && done) done <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (fill_done) begin
        data_mem[lat_idx] <= mem_rdata;
        tag_mem[lat_idx]  <= lat_addr[7:4];
      end else if (store_upd) begin
        data_mem[idx] <= cpu_wdata;
      end
    end
  end

endmodule
